// File: rtl/sodor_dmem_arbiter.sv
// Core/host arbiter for one single-ported data memory; optional grant statistics under SODOR_DMEM_ARB_STATS_EN.
// Latency: grant is combinational, and the response returns one cycle after the grant.
// Backpressure: the core has priority, the host wins when starved, and a host lock blocks the core.
module sodor_dmem_arbiter #(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned STARVE_LIMIT = 4
`ifdef SODOR_DMEM_ARB_STATS_EN
  ,
  parameter int unsigned CNT_W        = 16
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              core_req_valid,
  output logic              core_req_ready,
  input  logic [ADDR_W-1:0] core_req_addr,
  input  logic [31:0]       core_req_wdata,
  input  logic [3:0]        core_req_wmask,
  output logic              core_resp_valid,
  output logic [31:0]       core_resp_rdata,
  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic [ADDR_W-1:0] host_req_addr,
  input  logic [31:0]       host_req_wdata,
  input  logic [3:0]        host_req_wmask,
  input  logic              host_req_lock,
  output logic              host_resp_valid,
  output logic [31:0]       host_resp_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [31:0]       mem_rdata
`ifdef SODOR_DMEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  core_grant_cnt,
  output logic [CNT_W-1:0]  host_grant_cnt,
  output logic [CNT_W-1:0]  forced_grant_cnt
`endif
);

  localparam int unsigned     SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0]   STARVE_ONE = SW'(1);

  typedef enum logic {ST_OPEN, ST_HOST_LOCKED} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
  logic            resp_pending_q, resp_host_q, resp_is_read_q;
  logic            core_win, host_win, host_forced;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_OPEN;
      starve_cnt_q   <= '0;
      resp_pending_q <= 1'b0;
      resp_host_q    <= 1'b0;
      resp_is_read_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      starve_cnt_q   <= starve_cnt_d;
      resp_pending_q <= core_win | host_win;
      resp_host_q    <= host_win;
      resp_is_read_q <= host_win ? (host_req_wmask == 4'b0000) : (core_req_wmask == 4'b0000);
    end
  end

  // Grants are gated by reset_n so every output reads 0 while reset is held.
  always_comb begin
    core_win     = 1'b0;
    host_win     = 1'b0;
    host_forced  = 1'b0;
    state_d      = state_q;
    starve_cnt_d = '0;
    if (reset_n) begin
      if (state_q == ST_HOST_LOCKED) begin
        host_win = host_req_valid;
      end else if (host_req_valid && starve_cnt_q == STARVE_MAX) begin
        host_win    = 1'b1;
        host_forced = 1'b1;
      end else if (core_req_valid) begin
        core_win = 1'b1;
      end else begin
        host_win = host_req_valid;
      end
    end
    if (host_win) begin
      state_d = host_req_lock ? ST_HOST_LOCKED : ST_OPEN;
    end
    if (host_req_valid && !host_win) begin
      starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? STARVE_MAX : starve_cnt_q + STARVE_ONE;
    end
  end

  assign core_req_ready  = core_win;
  assign host_req_ready  = host_win;
  assign mem_en          = core_win | host_win;
  assign mem_addr        = host_win ? host_req_addr  : (core_win ? core_req_addr  : '0);
  assign mem_wdata       = host_win ? host_req_wdata : (core_win ? core_req_wdata : '0);
  assign mem_wmask       = host_win ? host_req_wmask : (core_win ? core_req_wmask : '0);

  assign core_resp_valid = resp_pending_q & ~resp_host_q;
  assign host_resp_valid = resp_pending_q &  resp_host_q;
  assign core_resp_rdata = (core_resp_valid && resp_is_read_q) ? mem_rdata : 32'h0;
  assign host_resp_rdata = (host_resp_valid && resp_is_read_q) ? mem_rdata : 32'h0;

`ifdef SODOR_DMEM_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_grant_cnt   <= '0;
      host_grant_cnt   <= '0;
      forced_grant_cnt <= '0;
    end else begin
      if (core_win && core_grant_cnt != '1)
        core_grant_cnt <= core_grant_cnt + CNT_ONE;
      if (host_win && host_grant_cnt != '1)
        host_grant_cnt <= host_grant_cnt + CNT_ONE;
      if (host_forced && forced_grant_cnt != '1)
        forced_grant_cnt <= forced_grant_cnt + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_sodor_dmem_arbiter.sv
// Bench for sodor_dmem_arbiter: memory responder, cycle-level reference model, directed and random stimulus.
module tb_sodor_dmem_arbiter;

  localparam int AW    = 4;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          core_req_valid, core_req_ready;
  logic [AW-1:0] core_req_addr;
  logic [31:0]   core_req_wdata;
  logic [3:0]    core_req_wmask;
  logic          core_resp_valid;
  logic [31:0]   core_resp_rdata;
  logic          host_req_valid, host_req_ready;
  logic [AW-1:0] host_req_addr;
  logic [31:0]   host_req_wdata;
  logic [3:0]    host_req_wmask;
  logic          host_req_lock;
  logic          host_resp_valid;
  logic [31:0]   host_resp_rdata;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;
  logic [31:0]   mem_rdata;
`ifdef SODOR_DMEM_ARB_STATS_EN
  logic [15:0]   core_grant_cnt, host_grant_cnt, forced_grant_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  sodor_dmem_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
    .core_req_wmask(core_req_wmask), .core_resp_valid(core_resp_valid),
    .core_resp_rdata(core_resp_rdata),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_req_addr(host_req_addr), .host_req_wdata(host_req_wdata),
    .host_req_wmask(host_req_wmask), .host_req_lock(host_req_lock),
    .host_resp_valid(host_resp_valid), .host_resp_rdata(host_resp_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
`ifdef SODOR_DMEM_ARB_STATS_EN
    , .core_grant_cnt(core_grant_cnt), .host_grant_cnt(host_grant_cnt),
    .forced_grant_cnt(forced_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Byte-masked single-port memory with one cycle of read latency.
  logic [31:0] mem [1<<AW];
  logic [31:0] rd_q;
  assign mem_rdata = rd_q;
  initial for (int k = 0; k < (1 << AW); k++) mem[k] = k * 32'h11111111;
  always @(posedge clk) begin
    if (mem_en) begin
      rd_q <= mem[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  // Reference model: who may access memory this cycle, and which response is owed.
  bit          m_locked;
  int          m_wait;
  bit          m_rsp, m_rsp_host;
  logic [31:0] m_rsp_data;
  int          m_core_g, m_host_g, m_forced_g;

  always @(negedge clk) begin
    bit          ec, eh, ef;
    logic [AW-1:0] ea;
    logic [31:0] ed;
    logic [3:0]  em;
    if (!reset_n) begin
      chk("rst_core_ready", core_req_ready, 0);
      chk("rst_host_ready", host_req_ready, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_core_resp", core_resp_valid, 0);
      chk("rst_host_resp", host_resp_valid, 0);
      chk("rst_core_rdata", core_resp_rdata, 0);
      m_locked = 0; m_wait = 0; m_rsp = 0;
      m_core_g = 0; m_host_g = 0; m_forced_g = 0;
    end else begin
      chk("core_resp_valid", core_resp_valid, m_rsp && !m_rsp_host);
      chk("host_resp_valid", host_resp_valid, m_rsp && m_rsp_host);
      chk("core_resp_rdata", core_resp_rdata, (m_rsp && !m_rsp_host) ? m_rsp_data : 32'h0);
      chk("host_resp_rdata", host_resp_rdata, (m_rsp && m_rsp_host) ? m_rsp_data : 32'h0);
`ifdef SODOR_DMEM_ARB_STATS_EN
      chk("core_grant_cnt", core_grant_cnt, m_core_g);
      chk("host_grant_cnt", host_grant_cnt, m_host_g);
      chk("forced_grant_cnt", forced_grant_cnt, m_forced_g);
`endif
      ec = 0; eh = 0; ef = 0;
      if (m_locked) eh = host_req_valid;
      else if (host_req_valid && m_wait >= LIMIT) begin eh = 1; ef = 1; end
      else if (core_req_valid) ec = 1;
      else eh = host_req_valid;
      ea = eh ? host_req_addr  : (ec ? core_req_addr  : '0);
      ed = eh ? host_req_wdata : (ec ? core_req_wdata : '0);
      em = eh ? host_req_wmask : (ec ? core_req_wmask : '0);
      chk("core_req_ready", core_req_ready, ec);
      chk("host_req_ready", host_req_ready, eh);
      chk("mem_en", mem_en, ec | eh);
      chk("mem_addr", mem_addr, ea);
      chk("mem_wdata", mem_wdata, ed);
      chk("mem_wmask", mem_wmask, em);
      m_rsp      = ec | eh;
      m_rsp_host = eh;
      m_rsp_data = (em == 4'b0000) ? mem[ea] : 32'h0;
      m_wait     = (host_req_valid && !eh) ? ((m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1) : 0;
      if (eh) m_locked = host_req_lock;
      if (ec) m_core_g++;
      if (eh) m_host_g++;
      if (ef) m_forced_g++;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic core_drive(input bit v, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
    core_req_valid = v; core_req_addr = a; core_req_wdata = d; core_req_wmask = m;
  endtask

  task automatic host_drive(input bit v, input logic [AW-1:0] a, input logic [31:0] d,
                            input logic [3:0] m, input bit l);
    host_req_valid = v; host_req_addr = a; host_req_wdata = d; host_req_wmask = m; host_req_lock = l;
  endtask

  initial begin
    bit c_gnt, h_gnt;
    reset_n = 1'b0;
    core_drive(1, 4'd2, 32'h0, 4'h0);
    host_drive(0, 4'd0, 32'h0, 4'h0, 0);
    cycle(); cycle();
    #1;
    chk("lit_reset_ready", core_req_ready, 0);
    chk("lit_reset_mem_en", mem_en, 0);
    core_drive(0, 0, 0, 0);
    cycle();
    reset_n = 1'b1;
    cycle();

    // Single core read of address 5.
    core_drive(1, 4'd5, 32'h0, 4'h0);
    #1;
    chk("lit_rd5_mem_en", mem_en, 1);
    chk("lit_rd5_addr", mem_addr, 5);
    cycle();
    core_drive(0, 0, 0, 0);
    #1;
    chk("lit_rd5_valid", core_resp_valid, 1);
    chk("lit_rd5_data", core_resp_rdata, 32'h55555555);
    chk("lit_rd5_host_valid", host_resp_valid, 0);
    cycle();

    // Back-to-back core reads 1, 2, 3.
    for (int i = 1; i <= 4; i++) begin
      if (i <= 3) core_drive(1, AW'(i), 32'h0, 4'h0);
      else core_drive(0, 0, 0, 0);
      #1;
      if (i > 1) begin
        chk("lit_b2b_valid", core_resp_valid, 1);
        chk("lit_b2b_data", core_resp_rdata, (i - 1) * 32'h11111111);
      end
      cycle();
    end

    // Both request every cycle: four core wins, then a forced host win.
    core_drive(1, 4'd0, 32'h0, 4'h0);
    host_drive(1, 4'd1, 32'h0, 4'h0, 0);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("lit_starve_core", core_req_ready, i != 4);
      chk("lit_starve_host", host_req_ready, i == 4);
      cycle();
    end
    core_drive(0, 0, 0, 0);
    host_drive(0, 0, 0, 0, 0);
`ifdef SODOR_DMEM_ARB_STATS_EN
    #1;
    chk("lit_forced_cnt", forced_grant_cnt, 1);
    chk("lit_host_cnt", host_grant_cnt, 1);
`endif
    cycle();

    // Host locked read-modify-write of address 3.
    host_drive(1, 4'd3, 32'hdeadbeef, 4'b0011, 1);
    #1;
    chk("lit_lock_host_ready", host_req_ready, 1);
    cycle();
    host_drive(0, 0, 0, 0, 0);
    core_drive(1, 4'd3, 32'h0, 4'h0);
    #1;
    chk("lit_lock_core_stall", core_req_ready, 0);
    cycle();
    #1;
    chk("lit_lock_core_stall2", core_req_ready, 0);
    host_drive(1, 4'd3, 32'h0, 4'h0, 0);
    cycle();
    host_drive(0, 0, 0, 0, 0);
    #1;
    chk("lit_lock_host_rvalid", host_resp_valid, 1);
    chk("lit_lock_host_rdata", host_resp_rdata, 32'h3333beef);
    chk("lit_unlock_core_ready", core_req_ready, 1);
    cycle();
    core_drive(0, 0, 0, 0);
    #1;
    chk("lit_core_after_lock", core_resp_rdata, 32'h3333beef);
    cycle();

    // Reset lands between grant and response.
    core_drive(1, 4'd7, 32'h0, 4'h0);
    cycle();
    reset_n = 1'b0;
    core_drive(0, 0, 0, 0);
    #1;
    chk("lit_rst_drop_valid", core_resp_valid, 0);
    chk("lit_rst_drop_rdata", core_resp_rdata, 0);
`ifdef SODOR_DMEM_ARB_STATS_EN
    chk("lit_rst_cnt", core_grant_cnt, 0);
`endif
    cycle();
    reset_n = 1'b1;
    core_drive(1, 4'd0, 32'h0, 4'h0);
    host_drive(1, 4'd1, 32'h0, 4'h0, 0);
    #1;
    chk("lit_rst_open_core", core_req_ready, 1);
    cycle();
    core_drive(0, 0, 0, 0);
    host_drive(0, 0, 0, 0, 0);
    cycle();
    cycle();

    // Core store to the top address, then read it back.
    core_drive(1, 4'd15, 32'h12345678, 4'b1111);
    cycle();
    core_drive(1, 4'd15, 32'h0, 4'h0);
    #1;
    chk("lit_wack_valid", core_resp_valid, 1);
    chk("lit_wack_rdata", core_resp_rdata, 0);
    cycle();
    core_drive(0, 0, 0, 0);
    #1;
    chk("lit_store_readback", core_resp_rdata, 32'h12345678);
    cycle();

    // Random traffic; payload is held stable until granted.
    c_gnt = 0; h_gnt = 0;
    for (int n = 0; n < 800; n++) begin
      if (!core_req_valid || c_gnt)
        core_drive($urandom_range(0, 2) != 0, AW'($urandom), $urandom,
                   $urandom_range(0, 1) ? 4'h0 : 4'($urandom));
      if (!host_req_valid || h_gnt)
        host_drive($urandom_range(0, 1) != 0, AW'($urandom), $urandom,
                   $urandom_range(0, 1) ? 4'h0 : 4'($urandom), $urandom_range(0, 3) == 0);
      #1;
      c_gnt = core_req_valid & core_req_ready;
      h_gnt = host_req_valid & host_req_ready;
      cycle();
    end
    core_drive(0, 0, 0, 0);
    host_drive(0, 0, 0, 0, 0);
    cycle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
